cpu_commit: RTL and testbench

//  Commit stage directly downstream of the ALU functions. Accepts one EXECUTE result per

---
 rtl/lib_cpu.sv | 31 +++
 rtl/cpu_commit.sv | 188 ++++++++++++++++++
 tb/tb_cpu_commit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/lib_cpu.sv
// Shared CPU types: execute-stage result payload and commit-stage FSM encoding.
package lib_cpu;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned MEM_AW       = 6;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned COMMIT_TMO_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM    = 2'd1,
    TX     = 2'd2,
    COMMIT = 2'd3
  } commit_state_t;

  typedef struct packed {
    logic [XLEN-1:0]   x_rd;
    logic              w_rd;
    logic              mem_r_req;
    logic              mem_w_req;
    logic [MEM_AW-1:0] mem_addr;
    logic              w_req;
    logic [BYTE_W-1:0] w_data;
    logic              ack;
    logic [XLEN-1:0]   pc;
    logic              intr_en;
    logic [XLEN-1:0]   intr_pc;
    logic [XLEN-1:0]   intr_vec;
  } execute_t;

endpackage

// File: rtl/cpu_commit.sv
// Commit stage: performs dmem access, UART handoff and interrupt ack for one EXECUTE
// result, writes rd, then updates architectural state.
module cpu_commit
  import lib_cpu::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'd0,
  parameter int unsigned     REG_AW   = 4,
  parameter int unsigned     MEM_TMO  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  execute_t          ex,
  input  logic [REG_AW-1:0] rd_idx,
  input  logic [XLEN-1:0]   st_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [MEM_AW-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_ack,
  output logic              tx_valid,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic              intr_ack,
  output logic [XLEN-1:0]   pc,
  output logic              intr_en,
  output logic [XLEN-1:0]   intr_pc,
  output logic [XLEN-1:0]   intr_vec,
  output logic              mem_err,
  output logic [XLEN-1:0]   retired
);

  commit_state_t           state_q, state_d;
  execute_t                ex_q, ex_nxt;
  logic [REG_AW-1:0]       rd_idx_q, rd_idx_nxt;
  logic [XLEN-1:0]         st_data_q, st_data_nxt;
  logic [XLEN-1:0]         rdata_q, rdata_nxt;
  logic [COMMIT_TMO_W-1:0] tmo_q;
  logic                    xfer, tmo_hit, mem_done;

  logic                    ex_ready_d, rf_we_d, dmem_req_d, dmem_we_d, tx_valid_d, intr_ack_d;
  logic [REG_AW-1:0]       rf_waddr_d;
  logic [XLEN-1:0]         rf_wdata_d, dmem_wdata_d;
  logic [MEM_AW-1:0]       dmem_addr_d;
  logic [BYTE_W-1:0]       tx_data_d;

  assign xfer     = ex_valid & ex_ready;
  // An ack arriving on the last allowed cycle takes precedence over the timeout.
  assign tmo_hit  = (state_q == MEM) & ~dmem_ack & (tmo_q == COMMIT_TMO_W'(MEM_TMO - 1));
  assign mem_done = (state_q == MEM) & (dmem_ack | tmo_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (ex.mem_r_req | ex.mem_w_req) state_d = MEM;
          else if (ex.w_req)               state_d = TX;
          else                             state_d = COMMIT;
        end
      end
      MEM:     if (mem_done) state_d = ex_q.w_req ? TX : COMMIT;
      TX:      if (tx_ready) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the latched payload, so registered outputs line up with state_q.
  always_comb begin
    ex_nxt      = ex_q;
    rd_idx_nxt  = rd_idx_q;
    st_data_nxt = st_data_q;
    rdata_nxt   = rdata_q;
    if (xfer) begin
      ex_nxt      = ex;
      rd_idx_nxt  = rd_idx;
      st_data_nxt = st_data;
    end
    if ((state_q == MEM) && dmem_ack) rdata_nxt = dmem_rdata;
    else if (tmo_hit)                 rdata_nxt = '0;
  end

  always_comb begin
    ex_ready_d   = 1'b0;
    rf_we_d      = 1'b0;
    rf_waddr_d   = '0;
    rf_wdata_d   = '0;
    dmem_req_d   = 1'b0;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = '0;
    dmem_wdata_d = '0;
    tx_valid_d   = 1'b0;
    tx_data_d    = '0;
    intr_ack_d   = 1'b0;
    unique case (state_d)
      IDLE: ex_ready_d = 1'b1;
      MEM: begin
        dmem_req_d   = 1'b1;
        dmem_we_d    = ex_nxt.mem_w_req;
        dmem_addr_d  = ex_nxt.mem_addr;
        dmem_wdata_d = st_data_nxt;
      end
      TX: begin
        tx_valid_d = 1'b1;
        tx_data_d  = ex_nxt.w_data;
      end
      COMMIT: begin
        // A combined read+write request behaves as a store: no rd update.
        rf_we_d    = ex_nxt.w_rd & (rd_idx_nxt != '0) & ~(ex_nxt.mem_r_req & ex_nxt.mem_w_req);
        rf_waddr_d = rd_idx_nxt;
        rf_wdata_d = (ex_nxt.mem_r_req & ~ex_nxt.mem_w_req) ? rdata_nxt : ex_nxt.x_rd;
        intr_ack_d = ex_nxt.ack;
      end
      default: ex_ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ready   <= 1'b1;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      intr_ack   <= 1'b0;
    end else begin
      ex_ready   <= ex_ready_d;
      rf_we      <= rf_we_d;
      rf_waddr   <= rf_waddr_d;
      rf_wdata   <= rf_wdata_d;
      dmem_req   <= dmem_req_d;
      dmem_we    <= dmem_we_d;
      dmem_addr  <= dmem_addr_d;
      dmem_wdata <= dmem_wdata_d;
      tx_valid   <= tx_valid_d;
      tx_data    <= tx_data_d;
      intr_ack   <= intr_ack_d;
    end
  end

  // Payload latches, MEM cycle counter and architectural state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      rd_idx_q  <= '0;
      st_data_q <= '0;
      rdata_q   <= '0;
      tmo_q     <= '0;
      pc        <= RESET_PC;
      intr_en   <= 1'b0;
      intr_pc   <= '0;
      intr_vec  <= '0;
      mem_err   <= 1'b0;
      retired   <= '0;
    end else begin
      ex_q      <= ex_nxt;
      rd_idx_q  <= rd_idx_nxt;
      st_data_q <= st_data_nxt;
      rdata_q   <= rdata_nxt;
      tmo_q     <= (state_q == MEM) ? tmo_q + COMMIT_TMO_W'(1) : '0;
      if (tmo_hit) mem_err <= 1'b1;
      if (state_q == COMMIT) begin
        pc       <= ex_q.pc;
        intr_en  <= ex_q.intr_en;
        intr_pc  <= ex_q.intr_pc;
        intr_vec <= ex_q.intr_vec;
        retired  <= retired + XLEN'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_commit.sv
// Directed vector bench for cpu_commit: table of single-instruction transactions plus reset corner case.
module tb_cpu_commit;
  import lib_cpu::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  execute_t    ex = '0;
  logic [3:0]  rd_idx = '0;
  logic [31:0] st_data = '0;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        dmem_req, dmem_we;
  logic [5:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        intr_ack;
  logic [31:0] pc, intr_pc, intr_vec, retired;
  logic        intr_en, mem_err;

  int n_vec = 0;
  int n_err = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  cpu_commit #(.RESET_PC(RST_PC), .REG_AW(4), .MEM_TMO(15)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex(ex),
    .rd_idx(rd_idx), .st_data(st_data), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .intr_ack(intr_ack),
    .pc(pc), .intr_en(intr_en), .intr_pc(intr_pc), .intr_vec(intr_vec),
    .mem_err(mem_err), .retired(retired)
  );

  typedef struct {
    execute_t    ex;
    logic [3:0]  rd;
    logic [31:0] st;
    int          ack_dly;
    logic [31:0] rdata;
    int          tx_dly;
    int          exp_mem_cyc;
    int          exp_tx_cyc;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic        exp_mem_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic execute_t mk(input logic [31:0] x_rd, input logic w_rd, input logic mr,
                                  input logic mw, input logic [5:0] addr, input logic wr,
                                  input logic [7:0] wd, input logic ack, input logic [31:0] npc,
                                  input logic ien, input logic [31:0] ipc, input logic [31:0] ivec);
    execute_t e;
    e.x_rd = x_rd; e.w_rd = w_rd; e.mem_r_req = mr; e.mem_w_req = mw; e.mem_addr = addr;
    e.w_req = wr; e.w_data = wd; e.ack = ack; e.pc = npc; e.intr_en = ien;
    e.intr_pc = ipc; e.intr_vec = ivec;
    return e;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int mem_cyc = 0;
    int tx_cyc = 0;
    bit done = 0;
    @(negedge clk);
    check({tag, "_ex_ready_idle"}, 32'(ex_ready), 32'd1);
    ex_valid = 1'b1; ex = v.ex; rd_idx = v.rd; st_data = v.st;
    @(negedge clk);
    ex_valid = 1'b0; ex = '0; rd_idx = '0; st_data = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      dmem_ack = 1'b0; tx_ready = 1'b0; dmem_rdata = '0;
      if (dmem_req) begin
        if (mem_cyc == 0) begin
          check({tag, "_dmem_addr"}, 32'(dmem_addr), 32'(v.ex.mem_addr));
          check({tag, "_dmem_we"}, 32'(dmem_we), 32'(v.ex.mem_w_req));
          check({tag, "_dmem_wdata"}, dmem_wdata, v.st);
        end
        check({tag, "_ex_ready_busy"}, 32'(ex_ready), 32'd0);
        if (mem_cyc == v.ack_dly) begin
          dmem_ack = 1'b1; dmem_rdata = v.rdata;
        end
        mem_cyc++;
      end else if (tx_valid) begin
        check({tag, "_tx_data"}, 32'(tx_data), 32'(v.ex.w_data));
        if (tx_cyc >= v.tx_dly) tx_ready = 1'b1;
        tx_cyc++;
      end else if (!ex_ready) begin
        check({tag, "_rf_we"}, 32'(rf_we), 32'(v.exp_we));
        if (v.exp_we) begin
          check({tag, "_rf_waddr"}, 32'(rf_waddr), 32'(v.rd));
          check({tag, "_rf_wdata"}, rf_wdata, v.exp_wdata);
        end
        check({tag, "_intr_ack"}, 32'(intr_ack), 32'(v.ex.ack));
        done = 1;
      end
      @(negedge clk);
    end
    dmem_ack = 1'b0; tx_ready = 1'b0; dmem_rdata = '0;
    if (!done) check({tag, "_commit_seen"}, 32'd0, 32'd1);
    exp_ret++;
    check({tag, "_mem_cycles"}, 32'(mem_cyc), 32'(v.exp_mem_cyc));
    check({tag, "_tx_cycles"}, 32'(tx_cyc), 32'(v.exp_tx_cyc));
    check({tag, "_pc"}, pc, v.ex.pc);
    check({tag, "_intr_en"}, 32'(intr_en), 32'(v.ex.intr_en));
    check({tag, "_intr_pc"}, intr_pc, v.ex.intr_pc);
    check({tag, "_intr_vec"}, intr_vec, v.ex.intr_vec);
    check({tag, "_retired"}, retired, 32'(exp_ret));
    check({tag, "_mem_err"}, 32'(mem_err), 32'(v.exp_mem_err));
    check({tag, "_strobes_idle"}, {30'd0, rf_we, intr_ack}, 32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    //        x_rd         w_rd mr mw addr  wr wd     ack pc          ien ipc    ivec
    vecs[0]  = '{mk(32'h5,        1, 0, 0, 6'h00, 0, 8'h00, 0, 32'h04, 1, 32'h0,  32'h0),
                 4'd3, 32'h0, -1, 32'h0, 0, 0, 0, 1'b1, 32'h5, 1'b0};
    vecs[1]  = '{mk(32'h1234,     1, 1, 0, 6'h2A, 0, 8'h00, 0, 32'h08, 1, 32'h0,  32'h0),
                 4'd5, 32'h0, 3, 32'hDEAD_BEEF, 0, 4, 0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{mk(32'h0,        1, 1, 0, 6'h03, 0, 8'h00, 0, 32'h0C, 1, 32'h0,  32'h0),
                 4'd2, 32'h0, 14, 32'h0000_CAFE, 0, 15, 0, 1'b1, 32'h0000_CAFE, 1'b0};
    vecs[3]  = '{mk(32'h0,        0, 0, 1, 6'h01, 0, 8'h00, 0, 32'h10, 1, 32'h0,  32'h0),
                 4'd0, 32'h77, -1, 32'h0, 0, 15, 0, 1'b0, 32'h0, 1'b1};
    vecs[4]  = '{mk(32'h0,        0, 0, 0, 6'h00, 1, 8'h41, 0, 32'h14, 1, 32'h0,  32'h0),
                 4'd0, 32'h0, -1, 32'h0, 5, 0, 6, 1'b0, 32'h0, 1'b1};
    vecs[5]  = '{mk(32'h18,       1, 0, 0, 6'h00, 0, 8'h00, 0, 32'h40, 0, 32'h10, 32'h40),
                 4'd0, 32'h0, -1, 32'h0, 0, 0, 0, 1'b0, 32'h0, 1'b1};
    vecs[6]  = '{mk(32'h0,        0, 0, 0, 6'h00, 0, 8'h00, 1, 32'h10, 1, 32'h10, 32'h40),
                 4'd0, 32'h0, -1, 32'h0, 0, 0, 0, 1'b0, 32'h0, 1'b1};
    vecs[7]  = '{mk(32'h33,       1, 1, 1, 6'h3F, 0, 8'h00, 0, 32'h14, 1, 32'h10, 32'h40),
                 4'd7, 32'hAAAA_5555, 0, 32'h99, 0, 1, 0, 1'b0, 32'h0, 1'b1};
    vecs[8]  = '{mk(32'h0,        1, 1, 0, 6'h05, 1, 8'h5A, 0, 32'h18, 1, 32'h10, 32'h40),
                 4'd9, 32'h0, 0, 32'h11, 0, 1, 1, 1'b1, 32'h11, 1'b1};
    vecs[9]  = '{mk(32'h55,       1, 1, 0, 6'h07, 0, 8'h00, 0, 32'h1C, 1, 32'h10, 32'h40),
                 4'd4, 32'h0, -1, 32'h0, 0, 15, 0, 1'b1, 32'h0, 1'b1};
    vecs[10] = '{mk(32'hFFFF_FFFF, 1, 0, 0, 6'h00, 0, 8'h00, 0, 32'h1C, 1, 32'h10, 32'h40),
                 4'd15, 32'h0, -1, 32'h0, 0, 0, 0, 1'b1, 32'hFFFF_FFFF, 1'b1};

    repeat (2) @(negedge clk);
    check("rst_pc", pc, RST_PC);
    check("rst_retired", retired, 32'd0);
    check("rst_ex_ready", 32'(ex_ready), 32'd1);
    check("rst_outputs", {26'd0, dmem_req, tx_valid, rf_we, intr_ack, mem_err, intr_en}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a pending load.
    @(negedge clk);
    ex_valid = 1'b1; ex = mk(32'h0, 1, 1, 0, 6'h2A, 0, 8'h00, 0, 32'h80, 1, 32'h0, 32'h0);
    rd_idx = 4'd6;
    @(negedge clk);
    ex_valid = 1'b0; ex = '0; rd_idx = '0;
    repeat (2) @(negedge clk);
    check("rst_mid_dmem_req_before", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_dmem_req_drop", 32'(dmem_req), 32'd0);
    check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_pc", pc, RST_PC);
    check("rst_mid_retired", retired, 32'd0);
    check("rst_mid_mem_err", 32'(mem_err), 32'd0);
    check("rst_mid_ex_ready", 32'(ex_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("rst_mid_no_req", {30'd0, dmem_req, rf_we}, 32'd0);
    exp_ret = 0;
    run_txn(vecs[0], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
